twiddle_mult_pipe: RTL and testbench

TWIDDLE_MULT_PIPE -- requirements
Module: twiddle_mult_pipe

---
 rtl/twiddle_pkg.sv | 25 ++
 rtl/twiddle_rom.sv | 50 +++++
 rtl/twiddle_mult_pipe.sv | 127 ++++++++++++
 tb/tb_twiddle_mult_pipe.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/twiddle_pkg.sv
// Shared twiddle definitions: trivial-coefficient codes, unity scale and a
// quarter-wave cosine table in Q2.9 for a 128-point circle.
package twiddle_pkg;

  localparam int TW_UNITY   = 512;
  localparam int TW_MAX_LOG = 7;

  typedef enum logic [2:0] {
    TW_GEN,
    TW_P1,
    TW_MJ,
    TW_M1,
    TW_PJ
  } tw_code_t;

  // round(512*cos(2*pi*m/128)) for m = 0..32; other angles come from symmetry
  localparam logic [9:0] TW_COS_Q [0:32] = '{
    10'd512, 10'd511, 10'd510, 10'd506, 10'd502, 10'd497, 10'd490, 10'd482,
    10'd473, 10'd463, 10'd452, 10'd439, 10'd426, 10'd411, 10'd396, 10'd379,
    10'd362, 10'd344, 10'd325, 10'd305, 10'd284, 10'd263, 10'd241, 10'd219,
    10'd196, 10'd172, 10'd149, 10'd124, 10'd100, 10'd75,  10'd50,  10'd25,
    10'd0
  };

endpackage

// File: rtl/twiddle_rom.sv
// Combinational index-to-{code, cr, ci} lookup for W^k = exp(-j*2*pi*k/NPERIOD).
module twiddle_rom
  import twiddle_pkg::*;
#(
  parameter int NPERIOD    = 8,
  parameter int NBITScoeff = 11
) (
  input  logic [$clog2(NPERIOD)-1:0]  k,
  output tw_code_t                    code,
  output logic signed [NBITScoeff-1:0] cr,
  output logic signed [NBITScoeff-1:0] ci
);

  logic [TW_MAX_LOG-1:0] p;
  logic [5:0]            m;
  logic [5:0]            mc;
  logic signed [NBITScoeff-1:0] c_m;
  logic signed [NBITScoeff-1:0] c_c;

  always_comb begin
    // scale k onto the 128-point circle, then split into quadrant and offset
    p    = TW_MAX_LOG'(k) << (TW_MAX_LOG - $clog2(NPERIOD));
    m    = {1'b0, p[4:0]};
    mc   = 6'd32 - m;
    c_m  = NBITScoeff'(TW_COS_Q[m]);
    c_c  = NBITScoeff'(TW_COS_Q[mc]);
    code = TW_GEN;
    cr   = c_m;
    ci   = -c_c;
    case (p[6:5])
      2'd0: begin
        cr = c_m;   ci = -c_c;
        if (m == 6'd0) code = TW_P1;
      end
      2'd1: begin
        cr = -c_c;  ci = -c_m;
        if (m == 6'd0) code = TW_MJ;
      end
      2'd2: begin
        cr = -c_m;  ci = c_c;
        if (m == 6'd0) code = TW_M1;
      end
      default: begin
        cr = c_c;   ci = c_m;
        if (m == 6'd0) code = TW_PJ;
      end
    endcase
  end

endmodule

// File: rtl/twiddle_mult_pipe.sv
// Three-stage complex multiply of a sample stream by a rotating twiddle W^k,
// with multiplier-free handling of the four axis-aligned coefficients.
module twiddle_mult_pipe
  import twiddle_pkg::*;
#(
  parameter int NBITS      = 12,
  parameter int NBITScoeff = 11,
  parameter int NBITS_out  = NBITS + NBITScoeff + 1,
  parameter int NPERIOD    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     sof,
  input  logic                     inv,
  input  logic [2*NBITS-1:0]       muestra,
  output logic                     out_valid,
  output logic                     out_sof,
  output logic [2*NBITS_out-1:0]   result
);

  localparam int KW = $clog2(NPERIOD);
  localparam int SH = NBITScoeff - 2;

  logic [KW-1:0] k_reg;
  logic [KW-1:0] k_cur;

  tw_code_t                     rom_code;
  tw_code_t                     code_in;
  logic signed [NBITScoeff-1:0] rom_cr;
  logic signed [NBITScoeff-1:0] rom_ci;
  logic signed [NBITScoeff-1:0] ci_in;

  logic                         s1_valid, s1_sof;
  tw_code_t                     s1_code;
  logic signed [NBITS-1:0]      s1_mr, s1_mi;
  logic signed [NBITScoeff-1:0] s1_cr, s1_ci;

  logic                         s2_valid, s2_sof, s2_triv;
  logic signed [NBITS_out-1:0]  p_rr, p_ii, p_ri, p_ir, t_r, t_i;

  logic signed [NBITS_out-1:0]  mr_x, mi_x, cr_x, ci_x, r_sum, i_sum;

  assign k_cur = sof ? '0 : k_reg;

  twiddle_rom #(
    .NPERIOD    (NPERIOD),
    .NBITScoeff (NBITScoeff)
  ) u_rom (
    .k    (k_cur),
    .code (rom_code),
    .cr   (rom_cr),
    .ci   (rom_ci)
  );

  // conjugation swaps -j and +j; the other trivial codes are real
  always_comb begin
    code_in = rom_code;
    ci_in   = rom_ci;
    if (inv) begin
      ci_in = -rom_ci;
      if (rom_code == TW_MJ)      code_in = TW_PJ;
      else if (rom_code == TW_PJ) code_in = TW_MJ;
    end
  end

  assign mr_x  = NBITS_out'(s1_mr);
  assign mi_x  = NBITS_out'(s1_mi);
  assign cr_x  = NBITS_out'(s1_cr);
  assign ci_x  = NBITS_out'(s1_ci);
  assign r_sum = s2_triv ? t_r : (p_rr - p_ii);
  assign i_sum = s2_triv ? t_i : (p_ri + p_ir);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg     <= '0;
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_code   <= TW_GEN;
      s1_mr     <= '0;
      s1_mi     <= '0;
      s1_cr     <= '0;
      s1_ci     <= '0;
      s2_valid  <= 1'b0;
      s2_sof    <= 1'b0;
      s2_triv   <= 1'b0;
      p_rr      <= '0;
      p_ii      <= '0;
      p_ri      <= '0;
      p_ir      <= '0;
      t_r       <= '0;
      t_i       <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      result    <= '0;
    end else begin
      if (in_valid) k_reg <= k_cur + 1'b1;
      s1_valid <= in_valid;
      s1_sof   <= in_valid & sof;
      s1_code  <= code_in;
      s1_mr    <= muestra[2*NBITS-1:NBITS];
      s1_mi    <= muestra[NBITS-1:0];
      s1_cr    <= rom_cr;
      s1_ci    <= ci_in;

      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_triv  <= (s1_code != TW_GEN);
      p_rr     <= mr_x * cr_x;
      p_ii     <= mi_x * ci_x;
      p_ri     <= mr_x * ci_x;
      p_ir     <= mi_x * cr_x;
      case (s1_code)
        TW_P1:   begin t_r <= mr_x <<< SH;    t_i <= mi_x <<< SH;    end
        TW_MJ:   begin t_r <= mi_x <<< SH;    t_i <= (-mr_x) <<< SH; end
        TW_M1:   begin t_r <= (-mr_x) <<< SH; t_i <= (-mi_x) <<< SH; end
        TW_PJ:   begin t_r <= (-mi_x) <<< SH; t_i <= mr_x <<< SH;    end
        default: begin t_r <= '0;             t_i <= '0;             end
      endcase

      out_valid <= s2_valid;
      out_sof   <= s2_sof;
      if (s2_valid) result <= {r_sum, i_sum};
    end
  end

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// Directed bench for twiddle_mult_pipe (NPERIOD=8): trivial and general
// coefficients, conjugation, wrap, bubbles, mid-frame sof and reset.
module tb_twiddle_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        sof;
  logic        inv;
  logic [23:0] muestra;
  logic        out_valid;
  logic        out_sof;
  logic [47:0] result;

  int tests = 0;
  int fails = 0;
  int nstep = 0;

  // expectations for the last three steps; index 2 is due at the current check
  bit pv [3];
  bit ps [3];
  int pr [3];
  int pim[3];
  int last_r = 0;
  int last_i = 0;

  int seq_r [8] = '{512, 362, 0, -362, -512, -362, 0, 362};
  int seq_i [8] = '{0, -362, -512, -362, 0, 362, 512, 362};

  twiddle_mult_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sof       (sof),
    .inv       (inv),
    .muestra   (muestra),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int res_r();
    return int'($signed(result[47:24]));
  endfunction

  function automatic int res_i();
    return int'($signed(result[23:0]));
  endfunction

  task automatic clear_expect();
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; ps[i] = 1'b0; pr[i] = 0; pim[i] = 0;
    end
    last_r = 0;
    last_i = 0;
  endtask

  // Called at a falling edge: drive one input cycle, clock it, then check the
  // output belonging to the step issued two calls earlier.
  task automatic step(input bit v, input bit s, input bit iv, input int mr, input int mi,
                      input bit ev, input bit es, input int er, input int ei);
    in_valid = v;
    sof      = s;
    inv      = iv;
    muestra  = {12'(mr), 12'(mi)};
    for (int i = 2; i > 0; i--) begin
      pv[i] = pv[i-1]; ps[i] = ps[i-1]; pr[i] = pr[i-1]; pim[i] = pim[i-1];
    end
    pv[0] = ev; ps[0] = es; pr[0] = er; pim[0] = ei;
    @(posedge clk);
    @(negedge clk);
    nstep++;
    if (pv[2]) begin
      last_r = pr[2];
      last_i = pim[2];
    end
    $display("[TB] step %0d in v=%0b sof=%0b inv=%0b (%0d,%0d) out v=%0b sof=%0b (%0d,%0d)",
             nstep, v, s, iv, mr, mi, out_valid, out_sof, res_r(), res_i());
    check("out_valid", int'(out_valid), int'(pv[2]));
    check("out_sof",   int'(out_sof),   int'(ps[2]));
    check("result_re", res_r(), last_r);
    check("result_im", res_i(), last_i);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    sof      = 1'b0;
    inv      = 1'b0;
    muestra  = '0;
    clear_expect();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sof",   int'(out_sof),   0);
    check("rst_result",    int'(result != 48'd0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // frame 1: every twiddle once, bubble mid-frame carries an ignored sof
    step(1, 1, 0,   100,   -50, 1, 1,   51200,   -25600);  // k0 +1
    step(1, 0, 0,   100,   -50, 1, 0,   18100,   -54300);  // k1 general
    step(1, 0, 0,   100,   -50, 1, 0,  -25600,   -51200);  // k2 -j
    step(0, 1, 0,     7,     7, 0, 0,       0,        0);  // bubble
    step(1, 0, 1,   100,   -50, 1, 0,  -18100,    54300);  // k3 conj
    step(1, 0, 0,   100,   -50, 1, 0,  -51200,    25600);  // k4 -1
    step(1, 0, 0, -2048,  2047, 1, 0,     362, -1482390);  // k5 extremes
    step(1, 0, 0,   100,   -50, 1, 0,   25600,    51200);  // k6 +j
    step(1, 0, 0, -2048, -2048, 1, 0,       0, -1482752);  // k7
    step(1, 0, 0, -2048, -2048, 1, 0, -1048576, -1048576); // k0 wrap
    step(1, 0, 1,   100,   -50, 1, 0,   54300,    18100);  // k1 conj
    step(1, 0, 1,   100,   -50, 1, 0,   25600,    51200);  // k2 conj -> +j
    step(1, 0, 0,     1,     0, 1, 0,    -362,     -362);  // k3
    step(1, 0, 0, -2048, -2048, 1, 0, 1048576,  1048576);  // k4 negate min
    step(1, 1, 0,     1,     0, 1, 1,     512,        0);  // sof at k5 -> k0
    step(1, 0, 0,     1,     0, 1, 0,     362,     -362);  // k1
    step(1, 0, 0,     1,     0, 1, 0,       0,     -512);  // in flight
    step(1, 0, 0,     1,     0, 1, 0,    -362,     -362);  // in flight

    // reset with two samples in flight: neither may emerge
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid",  int'(out_valid), 0);
    check("midrst_result", int'(result != 48'd0), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_expect();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1, 0, 512,    0);  // k0 without sof
    step(1, 0, 0, 1, 0, 1, 0, 362, -362);  // k1

    // 20 back-to-back unit samples with one bubble after the tenth
    for (int n = 0; n < 20; n++) begin
      step(1, (n == 0), 0, 1, 0, 1, (n == 0), seq_r[n % 8], seq_i[n % 8]);
      if (n == 9) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
